mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory port between instruction
// fetch and data requesters, one transaction in flight, with response timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  logic [0:0] state_r;
  logic [9:0] cnt_r;
  logic       last_d_r;   // data side held the most recent grant
  logic       owner_d_r;  // data side owns the outstanding transaction

  logic idle_s;
  logic wait_s;
  logic d_win_s;
  logic req_any_s;
  logic take_s;
  logic resp_s;
  logic timeout_s;

  // Every qualifier includes rst_n so all outputs are quiet during reset.
  always_comb begin
    idle_s    = rst_n && (state_r == IDLE);
    wait_s    = rst_n && (state_r == WAIT);
    d_win_s   = d_req && (!i_req || !last_d_r);
    req_any_s = idle_s && (i_req || d_req);
    take_s    = req_any_s && m_gnt;
    resp_s    = wait_s && m_rvalid;
    timeout_s = wait_s && !m_rvalid && (cnt_r == TIMEOUT_CNT);
  end

  // Memory request payload follows the arbitration winner.
  always_comb begin
    m_req   = req_any_s;
    m_we    = 1'b0;
    m_addr  = 32'h0000_0000;
    m_wdata = 32'h0000_0000;
    m_wstrb = 4'b0000;
    if (req_any_s) begin
      if (d_win_s) begin
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_wstrb = d_wstrb;
      end else begin
        m_we    = 1'b0;
        m_addr  = i_addr;
        m_wdata = 32'h0000_0000;
        m_wstrb = 4'b0000;
      end
    end else begin
      m_we    = 1'b0;
      m_addr  = 32'h0000_0000;
      m_wdata = 32'h0000_0000;
      m_wstrb = 4'b0000;
    end
  end

  // Grants, responses and errors routed to the requester they belong to.
  always_comb begin
    d_gnt    = take_s && d_win_s;
    i_gnt    = take_s && !d_win_s;
    d_rvalid = resp_s && owner_d_r;
    i_rvalid = resp_s && !owner_d_r;
    d_err    = timeout_s && owner_d_r;
    i_err    = timeout_s && !owner_d_r;
    if (d_rvalid) begin
      d_rdata = m_rdata;
    end else begin
      d_rdata = 32'h0000_0000;
    end
    if (i_rvalid) begin
      i_rdata = m_rdata;
    end else begin
      i_rdata = 32'h0000_0000;
    end
  end

  // Transaction sequencing; reset leaves the pointer so data wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 10'd0;
      last_d_r  <= 1'b0;
      owner_d_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_s) begin
            state_r   <= WAIT;
            owner_d_r <= d_win_s;
            last_d_r  <= d_win_s;
            cnt_r     <= 10'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            state_r <= IDLE;
          end else if (cnt_r == TIMEOUT_CNT) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + 10'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 10'd0;
        end
      endcase
    end
  end

endmodule
